pll_reset_ctrl: RTL and testbench
=================================

# pll_reset_ctrl

Reset and lock supervisor for the on-board 27 MHz rPLL. Runs on the same crystal clock that feeds the PLL input, drives the PLL's `RESET` pin, and consumes its `LOCK` output. Issues one clean, glitch-free active-high system reset that releases only after lock has been continuously stable. Re-arms the PLL on lock timeout, lock loss, or software request; downstream clock domains (PLL `clkout`/`clkoutd`) re-synchronise `sys_rst` locally.

## Interface
- `LOCK_SYNC_STAGES`, 2: flops in the `pll_lock` synchroniser (≥2).
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse (≥1).
- `LOCK_TIMEOUT`, 270000: cycles to wait for lock before re-resetting the PLL (10 ms at 27 MHz).
- `STABLE_CYCLES`, 27000: cycles lock must stay high before `sys_rst` releases (1 ms).
- `CNT_W`, 8: width of the diagnostic counters.

Ports:
- `clk` in 1: 27 MHz crystal clock, same net as the PLL `clkin`.
- `rst` in 1: asynchronous, active-high, from the board/button.
- `pll_lock` in 1: PLL `LOCK`, asynchronous to `clk`.
- `relock_req` in 1: single-cycle synchronous pulse that forces a PLL re-arm.
- `pll_rst` out 1: to PLL `RESET`; registered.
- `sys_rst` out 1: active-high system reset; registered.
- `ready` out 1: high only in RUN; registered.
- `timeout_cnt` out CNT_W: number of lock timeouts, saturating.
- `loss_cnt` out CNT_W: number of lock losses while in RUN, saturating.

## Operation
- `pll_lock` passes through a `LOCK_SYNC_STAGES` synchroniser to give `lock_s`. No other logic samples `pll_lock` directly.
- One timer, width `$clog2(max(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES)+1)`, cleared on every state change.
- **PLL_RST**: `pll_rst`=1. After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
- **WAIT_LOCK**:
  - If `lock_s`=1, go to STABLE.
  - Else, when timer reaches `LOCK_TIMEOUT`-1, go to PLL_RST and increment `timeout_cnt`.
- **STABLE**:
  - If `lock_s`=0, go to WAIT_LOCK, with no counter change.
  - When timer reaches `STABLE_CYCLES`-1 with `lock_s`=1, go to RUN.
- **RUN**: `sys_rst`=0, `ready`=1. If `lock_s`=0, go to PLL_RST and increment `loss_cnt`.
- `relock_req`=1 in any state sends the FSM to PLL_RST. It increments no counter.
- Priority within a cycle: `relock_req` > lock-loss/lock-drop > timer expiry.
- `sys_rst`=1 in every state except RUN. All three outputs are registered decodes of the next state, so they change on the same edge as the state.
- Counters saturate at 2^CNT_W−1 and clear only on `rst`.

## Timing
- Reset values while `rst`=1: state PLL_RST, timer 0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `timeout_cnt`=0, `loss_cnt`=0, synchroniser flops 0.
- After `rst` falls, `pll_rst` stays high for exactly `PLL_RST_CYCLES` rising edges.
- Lock to release: a `pll_lock` rise that stays high releases `sys_rst` `LOCK_SYNC_STAGES`+1+`STABLE_CYCLES` edges later.
- Loss to reset: a `pll_lock` fall in RUN raises `sys_rst` and `pll_rst` `LOCK_SYNC_STAGES`+1 edges later.
- `relock_req` sampled high raises `sys_rst` and `pll_rst` on the next edge.
- Lock glitches shorter than one `clk` period may be missed. This is acceptable.
- Boundary conditions:
  - Lock dropping on the exact cycle STABLE would expire goes to WAIT_LOCK, not RUN.
  - `relock_req` held high keeps the FSM in PLL_RST with the timer pinned at 0.
  - Asserting `rst` mid-operation returns everything to reset values immediately, asynchronously.

## Structure
- Package `pll_rst_pkg`:
  - state enum `{PLL_RST, WAIT_LOCK, STABLE, RUN}`;
  - default constants for the timeout, stable and reset-pulse lengths at 27 MHz.
- Sub-module `bit_sync`: a parameterised N-flop synchroniser with async reset to 0, reused by the other domains for `sys_rst`.

## Test plan
All scenarios use `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `LOCK_SYNC_STAGES`=2, `CNT_W`=2.
1. Clean start:
   - Stimulus: release `rst`; raise `pll_lock` at edge 10 and hold it.
   - Required: `pll_rst` high for edges 1–4; `sys_rst` falls and `ready` rises at edge 10+2+1+8=21.
2. Timeout:
   - Stimulus: `pll_lock` held at 0.
   - Required: `pll_rst` re-pulses every 24 cycles; `timeout_cnt` reads 1, 2, 3, then stays at 3 (saturated).
3. Lock glitch in STABLE:
   - Stimulus: lock high for 5 cycles, low for 2, then high.
   - Required: FSM returns to WAIT_LOCK; release happens 11 edges after the final rise; `loss_cnt` stays 0.
4. Loss in RUN:
   - Stimulus: drop `pll_lock` while `ready`=1.
   - Required: 3 edges later `ready`=0, `sys_rst`=1, `pll_rst`=1 for 4 cycles; `loss_cnt`=1.
5. Software relock:
   - Stimulus: pulse `relock_req` in RUN, and again on the same cycle as a lock drop.
   - Required: PLL_RST entered next edge; `loss_cnt` unchanged in both cases.
6. Async reset mid-STABLE:
   - Stimulus: assert `rst` between clock edges.
   - Required: outputs go to reset values before the next edge; counters read 0.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared types and default timing constants for the PLL reset/lock supervisor.
//
// Contents:
//   state_t      - supervisor FSM states
//   DEF_*        - default timing lengths for a 27 MHz crystal clock
//   max3()       - helper used to size the shared timer
package pll_rst_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int unsigned DEF_LOCK_SYNC_STAGES = 2;
  localparam int unsigned DEF_PLL_RST_CYCLES   = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT     = 270000;  // 10 ms at 27 MHz
  localparam int unsigned DEF_STABLE_CYCLES    = 27000;   // 1 ms at 27 MHz
  localparam int unsigned DEF_CNT_W            = 8;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// N-flop single-bit synchroniser with asynchronous active-high reset to 0.
// Used for the PLL lock input here and by downstream clock domains to
// re-synchronise sys_rst.
//
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset; clears every stage
//   d   - asynchronous input bit
//   q   - synchronised output (last stage)
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a real shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// Reset and lock supervisor for the on-board rPLL. Pulses the PLL RESET pin,
// waits for LOCK, requires lock to stay stable before releasing a single
// registered system reset, and re-arms the PLL on timeout, lock loss or a
// software request.
//
// Ports:
//   clk         - crystal clock (same net as PLL clkin)
//   rst         - asynchronous active-high board reset
//   pll_lock    - PLL LOCK, asynchronous to clk
//   relock_req  - single-cycle synchronous request to re-arm the PLL
//   pll_rst     - to PLL RESET, registered
//   sys_rst     - active-high system reset, registered
//   ready       - high only in RUN, registered
//   timeout_cnt - saturating count of lock timeouts
//   loss_cnt    - saturating count of lock losses while in RUN
module pll_reset_ctrl
  import pll_rst_pkg::*;
#(
  parameter int unsigned LOCK_SYNC_STAGES = DEF_LOCK_SYNC_STAGES,
  parameter int unsigned PLL_RST_CYCLES   = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES    = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W            = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int unsigned TMAX = max3(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RST_LAST    = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);

  logic          lock_s;
  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic          timer_clr;
  logic          inc_timeout;
  logic          inc_loss;

  // The only consumer of the raw PLL lock signal.
  bit_sync #(
    .STAGES (LOCK_SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Priority: software relock, then lock loss/drop, then timer expiry.
  // NOTE: every signal written here gets a default first so no path through
  // the case leaves a value unassigned, which would infer a latch.
  always_comb begin
    next_state  = state;
    inc_timeout = 1'b0;
    inc_loss    = 1'b0;
    if (relock_req) begin
      next_state = PLL_RST;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (timer == RST_LAST) next_state = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            next_state = STABLE;
          end else if (timer == TIMEOUT_LAST) begin
            next_state  = PLL_RST;
            inc_timeout = 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s)                  next_state = WAIT_LOCK;
          else if (timer == STABLE_LAST) next_state = RUN;
        end
        RUN: begin
          if (!lock_s) begin
            next_state = PLL_RST;
            inc_loss   = 1'b1;
          end
        end
        default: next_state = PLL_RST;
      endcase
    end
    // A held relock_req re-enters PLL_RST every cycle, pinning the timer at 0.
    timer_clr = relock_req || (next_state != state);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PLL_RST;
      timer       <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      timeout_cnt <= '0;
      loss_cnt    <= '0;
    end else begin
      state <= next_state;

      // RUN never consults the timer; holding it avoids a meaningless wrap.
      if (timer_clr)          timer <= '0;
      else if (state != RUN)  timer <= timer + TW'(1);

      // Outputs decode next_state so they switch on the same edge as state.
      pll_rst <= (next_state == PLL_RST);
      sys_rst <= (next_state != RUN);
      ready   <= (next_state == RUN);

      if (inc_timeout && (timeout_cnt != '1)) timeout_cnt <= timeout_cnt + CNT_W'(1);
      if (inc_loss && (loss_cnt != '1))       loss_cnt    <= loss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed self-checking bench for pll_reset_ctrl with short timing
// parameters. Inputs change 1 time unit after a rising edge and outputs are
// sampled at that same point; edge_n counts rising edges since rst released.
module tb_pll_reset_ctrl;

  localparam int unsigned P_SYNC    = 2;
  localparam int unsigned P_RST     = 4;
  localparam int unsigned P_TIMEOUT = 20;
  localparam int unsigned P_STABLE  = 8;
  localparam int unsigned P_CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               pll_lock;
  logic               relock_req;
  logic               pll_rst;
  logic               sys_rst;
  logic               ready;
  logic [P_CNT_W-1:0] timeout_cnt;
  logic [P_CNT_W-1:0] loss_cnt;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  pll_reset_ctrl #(
    .LOCK_SYNC_STAGES (P_SYNC),
    .PLL_RST_CYCLES   (P_RST),
    .LOCK_TIMEOUT     (P_TIMEOUT),
    .STABLE_CYCLES    (P_STABLE),
    .CNT_W            (P_CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_lock    (pll_lock),
    .relock_req  (relock_req),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .timeout_cnt (timeout_cnt),
    .loss_cnt    (loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic to_edge(input int e);
    while (edge_n < e) step();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pll_lock   = 1'b0;
    relock_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    edge_n = 0;
  endtask

  // Outputs compared as {pll_rst, sys_rst, ready}.
  task automatic test_reset();
    rst        = 1'b1;
    pll_lock   = 1'b0;
    relock_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b110) begin
      errors++;
      $display("FAIL reset_outs: got %b expected 110", {pll_rst, sys_rst, ready});
    end
    checks++;
    if ({timeout_cnt, loss_cnt} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_cnts: got %b expected 0000", {timeout_cnt, loss_cnt});
    end
    rst    = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if (pll_rst !== 1'b1) begin
        errors++;
        $display("FAIL reset_pulse_e%0d: got %b expected 1", e, pll_rst);
      end
    end
    step();
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b010) begin
      errors++;
      $display("FAIL reset_pulse_end: got %b expected 010", {pll_rst, sys_rst, ready});
    end
  endtask

  task automatic test_clean_start();
    do_reset();
    to_edge(10);
    pll_lock = 1'b1;
    to_edge(20);
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b010) begin
      errors++;
      $display("FAIL clean_pre_release: got %b expected 010", {pll_rst, sys_rst, ready});
    end
    step();
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b001) begin
      errors++;
      $display("FAIL clean_release_e21: got %b expected 001", {pll_rst, sys_rst, ready});
    end
  endtask

  task automatic test_timeout();
    logic [P_CNT_W-1:0] exp_prev, exp_now;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      exp_prev = P_CNT_W'((k - 1 > 3) ? 3 : k - 1);
      exp_now  = P_CNT_W'((k > 3) ? 3 : k);
      to_edge(24 * k - 1);
      checks++;
      if ({pll_rst, timeout_cnt} !== {1'b0, exp_prev}) begin
        errors++;
        $display("FAIL timeout_before_%0d: got pll_rst=%b cnt=%0d expected 0/%0d",
                 k, pll_rst, timeout_cnt, exp_prev);
      end
      step();
      checks++;
      if ({pll_rst, timeout_cnt} !== {1'b1, exp_now}) begin
        errors++;
        $display("FAIL timeout_fire_%0d: got pll_rst=%b cnt=%0d expected 1/%0d",
                 k, pll_rst, timeout_cnt, exp_now);
      end
      to_edge(24 * k + 3);
      checks++;
      if (pll_rst !== 1'b1) begin
        errors++;
        $display("FAIL timeout_pulse_hold_%0d: got %b expected 1", k, pll_rst);
      end
      step();
      checks++;
      if (pll_rst !== 1'b0) begin
        errors++;
        $display("FAIL timeout_pulse_end_%0d: got %b expected 0", k, pll_rst);
      end
    end
  endtask

  task automatic test_stable_glitch();
    do_reset();
    to_edge(10);
    pll_lock = 1'b1;
    to_edge(15);
    pll_lock = 1'b0;
    to_edge(17);
    pll_lock = 1'b1;
    to_edge(21);
    checks++;
    if (sys_rst !== 1'b1) begin
      errors++;
      $display("FAIL glitch_no_early_release: got sys_rst=%b expected 1", sys_rst);
    end
    to_edge(27);
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b010) begin
      errors++;
      $display("FAIL glitch_pre_release: got %b expected 010", {pll_rst, sys_rst, ready});
    end
    step();
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b001) begin
      errors++;
      $display("FAIL glitch_release_e28: got %b expected 001", {pll_rst, sys_rst, ready});
    end
    checks++;
    if (loss_cnt !== 2'd0) begin
      errors++;
      $display("FAIL glitch_loss_cnt: got %0d expected 0", loss_cnt);
    end
  endtask

  // Lock drop seen on the very cycle STABLE would expire.
  task automatic test_stable_boundary();
    do_reset();
    to_edge(10);
    pll_lock = 1'b1;
    to_edge(18);
    pll_lock = 1'b0;
    to_edge(19);
    pll_lock = 1'b1;
    to_edge(21);
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b010) begin
      errors++;
      $display("FAIL boundary_no_run: got %b expected 010", {pll_rst, sys_rst, ready});
    end
    to_edge(29);
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b010) begin
      errors++;
      $display("FAIL boundary_pre_release: got %b expected 010", {pll_rst, sys_rst, ready});
    end
    step();
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b001) begin
      errors++;
      $display("FAIL boundary_release_e30: got %b expected 001", {pll_rst, sys_rst, ready});
    end
  endtask

  task automatic test_loss_in_run();
    do_reset();
    to_edge(10);
    pll_lock = 1'b1;
    to_edge(25);
    pll_lock = 1'b0;
    to_edge(27);
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b001) begin
      errors++;
      $display("FAIL loss_still_run: got %b expected 001", {pll_rst, sys_rst, ready});
    end
    step();
    checks++;
    if ({pll_rst, sys_rst, ready, loss_cnt} !== 5'b110_01) begin
      errors++;
      $display("FAIL loss_reset: got outs=%b loss=%0d expected 110/1",
               {pll_rst, sys_rst, ready}, loss_cnt);
    end
    to_edge(31);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL loss_pulse_hold: got %b expected 1", pll_rst);
    end
    step();
    checks++;
    if ({pll_rst, loss_cnt, timeout_cnt} !== 5'b0_01_00) begin
      errors++;
      $display("FAIL loss_pulse_end: got pll_rst=%b loss=%0d timeout=%0d expected 0/1/0",
               pll_rst, loss_cnt, timeout_cnt);
    end
  endtask

  task automatic test_relock();
    do_reset();
    to_edge(10);
    pll_lock = 1'b1;
    to_edge(23);
    relock_req = 1'b1;
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b001) begin
      errors++;
      $display("FAIL relock_in_run: got %b expected 001", {pll_rst, sys_rst, ready});
    end
    step();
    relock_req = 1'b0;
    checks++;
    if ({pll_rst, sys_rst, ready, loss_cnt} !== 5'b110_00) begin
      errors++;
      $display("FAIL relock_next_edge: got outs=%b loss=%0d expected 110/0",
               {pll_rst, sys_rst, ready}, loss_cnt);
    end
    to_edge(36);
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b010) begin
      errors++;
      $display("FAIL relock_pre_rerun: got %b expected 010", {pll_rst, sys_rst, ready});
    end
    step();
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b001) begin
      errors++;
      $display("FAIL relock_rerun_e37: got %b expected 001", {pll_rst, sys_rst, ready});
    end
    // Lock drop and relock_req land on the same edge (43); relock is then held.
    to_edge(40);
    pll_lock = 1'b0;
    to_edge(42);
    relock_req = 1'b1;
    step();
    checks++;
    if ({pll_rst, sys_rst, ready, loss_cnt} !== 5'b110_00) begin
      errors++;
      $display("FAIL relock_vs_loss: got outs=%b loss=%0d expected 110/0",
               {pll_rst, sys_rst, ready}, loss_cnt);
    end
    to_edge(48);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL relock_held: got %b expected 1", pll_rst);
    end
    to_edge(50);
    relock_req = 1'b0;
    to_edge(53);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL relock_release_hold: got %b expected 1", pll_rst);
    end
    step();
    checks++;
    if ({pll_rst, sys_rst, ready, loss_cnt, timeout_cnt} !== 7'b010_00_00) begin
      errors++;
      $display("FAIL relock_release_end: got outs=%b loss=%0d timeout=%0d expected 010/0/0",
               {pll_rst, sys_rst, ready}, loss_cnt, timeout_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    to_edge(24);
    checks++;
    if (timeout_cnt !== 2'd1) begin
      errors++;
      $display("FAIL async_pre_timeout: got %0d expected 1", timeout_cnt);
    end
    to_edge(30);
    pll_lock = 1'b1;
    to_edge(35);
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b010) begin
      errors++;
      $display("FAIL async_in_stable: got %b expected 010", {pll_rst, sys_rst, ready});
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b110) begin
      errors++;
      $display("FAIL async_outs: got %b expected 110", {pll_rst, sys_rst, ready});
    end
    checks++;
    if ({timeout_cnt, loss_cnt} !== 4'b0000) begin
      errors++;
      $display("FAIL async_cnts: got %b expected 0000", {timeout_cnt, loss_cnt});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_start();
    test_timeout();
    test_stable_glitch();
    test_stable_boundary();
    test_loss_in_run();
    test_relock();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
